// File: rtl/instr_encoder_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader_pkg
//   Shared opcode set and field widths for the MIPS subset (R, LW, SW, BEQ, J).
//   The control unit decodes the same opcodes that the loader encodes here.
//   No ports; imported by mips_instr_encode and instr_encoder_loader.
// -----------------------------------------------------------------------------
package instr_encoder_loader_pkg;

    // Instruction field widths
    localparam int unsigned OPC_W    = 6;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned TARGET_W = 26;
    localparam int unsigned KIND_W   = 3;
    localparam int unsigned WORD_W   = 32;

    // Primary opcodes (bits 31:26)
    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_J     = 6'b000010;

    // in_kind codes; 5..7 are unsupported and have no enum member
    typedef enum logic [KIND_W-1:0] {
        KIND_R   = 3'd0,
        KIND_LW  = 3'd1,
        KIND_SW  = 3'd2,
        KIND_BEQ = 3'd3,
        KIND_J   = 3'd4
    } kind_e;

    // Loader sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } load_state_e;

endpackage : instr_encoder_loader_pkg

// File: rtl/instr_encoder_loader_encode.sv
// -----------------------------------------------------------------------------
// mips_instr_encode
//   Purely combinational: packs one field bundle into a 32-bit MIPS word.
//   Ports:
//     kind_i        instruction kind code (0=R 1=LW 2=SW 3=BEQ 4=J)
//     rs_i, rt_i    source/target register fields
//     rd_i, funct_i destination register and function code (R only)
//     imm_i         16-bit immediate/offset (LW, SW, BEQ)
//     target_i      26-bit jump target (J)
//     word_o        encoded instruction word ('0 for unsupported kinds)
//     valid_kind_o  1 when kind_i is one of the five supported kinds
// -----------------------------------------------------------------------------
module mips_instr_encode
    import instr_encoder_loader_pkg::*;
(
    input  logic [KIND_W-1:0]   kind_i,
    input  logic [REG_W-1:0]    rs_i,
    input  logic [REG_W-1:0]    rt_i,
    input  logic [REG_W-1:0]    rd_i,
    input  logic [FUNCT_W-1:0]  funct_i,
    input  logic [IMM_W-1:0]    imm_i,
    input  logic [TARGET_W-1:0] target_i,
    output logic [WORD_W-1:0]   word_o,
    output logic                valid_kind_o
);

    always_comb begin
        word_o       = '0;
        valid_kind_o = 1'b0;
        case (kind_i)
            KIND_R: begin
                word_o       = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b00000, funct_i};
                valid_kind_o = 1'b1;
            end
            KIND_LW: begin
                word_o       = {OP_LW, rs_i, rt_i, imm_i};
                valid_kind_o = 1'b1;
            end
            KIND_SW: begin
                word_o       = {OP_SW, rs_i, rt_i, imm_i};
                valid_kind_o = 1'b1;
            end
            KIND_BEQ: begin
                word_o       = {OP_BEQ, rs_i, rt_i, imm_i};
                valid_kind_o = 1'b1;
            end
            KIND_J: begin
                word_o       = {OP_J, target_i};
                valid_kind_o = 1'b1;
            end
            default: begin
                word_o       = '0;
                valid_kind_o = 1'b0;
            end
        endcase
    end

endmodule : mips_instr_encode

// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//   Accepts instruction field bundles over a valid/ready stream, encodes each
//   into a MIPS word and writes it to instruction memory at consecutive word
//   addresses starting from 0. Holds the core stopped (cpu_run=0) until the
//   bundle flagged last has been written.
//   Ports:
//     clk, reset          rising-edge clock, synchronous active-high reset
//     start               pulse: begin a new load (from IDLE or DONE)
//     in_valid/in_ready   field bundle handshake
//     in_kind .. in_last  bundle fields and end-of-program flag
//     imem_we/addr/wdata  registered imem write port (one strobe per word)
//     word_count          words written in the current load
//     full                word_count == DEPTH
//     err_kind            sticky: an unsupported kind was accepted
//     cpu_run             program loaded, core may execute
// -----------------------------------------------------------------------------
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              err_kind,
    output logic              cpu_run
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    load_state_e       state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic              err_q, err_d;

    logic [31:0]       enc_word;
    logic              enc_valid;
    logic              accept;

    mips_instr_encode u_encode (
        .kind_i       (in_kind),
        .rs_i         (in_rs),
        .rt_i         (in_rt),
        .rd_i         (in_rd),
        .funct_i      (in_funct),
        .imm_i        (in_imm),
        .target_i     (in_target),
        .word_o       (enc_word),
        .valid_kind_o (enc_valid)
    );

    // ptr_q counts words accepted for writing and runs one cycle ahead of
    // word_count, which only advances once the write strobe has been issued.
    // Gating in_ready on ptr_q keeps a back-to-back stream from overrunning
    // DEPTH while the last write is still in flight; once that write retires
    // the two agree and in_ready is equivalent to LOAD && !full.
    assign in_ready = (state_q == ST_LOAD) && (ptr_q != DEPTH_C);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        err_d   = err_q;

        // A strobe issued this cycle retires into the count at the edge.
        if (we_q) begin
            count_d = count_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    ptr_d   = '0;
                    addr_d  = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (enc_valid) begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q[ADDR_W-1:0];
                        wdata_d = enc_word;
                        ptr_d   = ptr_q + 1'b1;
                    end else begin
                        err_d   = 1'b1;
                    end
                    if (in_last) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                // The final word's strobe (if any) is on the port this cycle.
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                    ptr_d   = '0;
                    addr_d  = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            count_q <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign word_count = count_q;
    assign full       = (count_q == DEPTH_C);
    assign err_kind   = err_q;
    assign cpu_run    = (state_q == ST_DONE);

endmodule : instr_encoder_loader

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    localparam int AW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, in_valid, in_last, sel_small;
    logic [2:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    logic          b_ready, b_we, b_full, b_err, b_run;
    logic [AW-1:0] b_addr;
    logic [31:0]   b_wdata;
    logic [AW:0]   b_count;
    logic          s_ready, s_we, s_full, s_err, s_run;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_wdata;
    logic [AW:0]   s_count;

    logic b_valid, s_valid;
    assign b_valid = in_valid & ~sel_small;
    assign s_valid = in_valid &  sel_small;

    instr_encoder_loader u_dut (
        .clk(clk), .reset(reset), .start(start & ~sel_small),
        .in_valid(b_valid), .in_ready(b_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
        .word_count(b_count), .full(b_full), .err_kind(b_err), .cpu_run(b_run)
    );

    instr_encoder_loader #(.ADDR_W(AW), .DEPTH(4)) u_small (
        .clk(clk), .reset(reset), .start(start & sel_small),
        .in_valid(s_valid), .in_ready(s_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
        .word_count(s_count), .full(s_full), .err_kind(s_err), .cpu_run(s_run)
    );

    // Outputs of whichever instance is under test
    logic          rdy_m, we_m, full_m, err_m, run_m;
    logic [AW-1:0] addr_m;
    logic [31:0]   wdata_m;
    logic [AW:0]   count_m;
    always_comb begin
        rdy_m   = sel_small ? s_ready : b_ready;
        we_m    = sel_small ? s_we    : b_we;
        full_m  = sel_small ? s_full  : b_full;
        err_m   = sel_small ? s_err   : b_err;
        run_m   = sel_small ? s_run   : b_run;
        addr_m  = sel_small ? s_addr  : b_addr;
        wdata_m = sel_small ? s_wdata : b_wdata;
        count_m = sel_small ? s_count : b_count;
    end

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          grp;
        logic [2:0]  kind;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
        logic        last;
        bit          exp_write;
        logic [31:0] exp_word;
    } vec_t;

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
        int unsigned c;
    } wr_t;

    vec_t table_v[$];
    vec_t prog_q[$];
    wr_t  wr_q[$];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (we_m === 1'b1) wr_q.push_back('{32'(addr_m), wdata_m, cyc});

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference encoding built from field weights, independent of bit slicing.
    function automatic logic [31:0] model_word(input vec_t v);
        longint unsigned w;
        longint unsigned regs;
        regs = longint'(v.rs) * (64'd1 << 21) + longint'(v.rt) * (64'd1 << 16);
        case (int'(v.kind))
            0: w = regs + longint'(v.rd) * (64'd1 << 11) + longint'(v.funct);
            1: w = 64'd35 * (64'd1 << 26) + regs + longint'(v.imm);
            2: w = 64'd43 * (64'd1 << 26) + regs + longint'(v.imm);
            3: w = 64'd4  * (64'd1 << 26) + regs + longint'(v.imm);
            4: w = 64'd2  * (64'd1 << 26) + longint'(v.target);
            default: w = 0;
        endcase
        return 32'(w);
    endfunction

    // Called just after a negedge; leaves in_valid asserted for back-to-back use.
    task automatic send(input vec_t v, input int budget, output bit acc, output int waited);
        in_valid  = 1'b1;
        in_kind   = v.kind;   in_rs  = v.rs;  in_rt = v.rt; in_rd = v.rd;
        in_funct  = v.funct;  in_imm = v.imm; in_target = v.target;
        in_last   = v.last;
        acc = 1'b0; waited = 0;
        while (!acc && waited <= budget) begin
            if (rdy_m === 1'b1) begin
                @(posedge clk);
                acc = 1'b1;
                @(negedge clk);
            end else begin
                @(negedge clk);
                waited++;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_program(input string tag, input bit gaps, input bit b2b);
        bit   acc;
        int   w, maxw, k, nexp;
        bit   exp_err;
        wr_t  exp_q[$];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".run_after_start"}, 64'(run_m), 64'd0);
        check({tag, ".count_after_start"}, 64'(count_m), 64'd0);
        check({tag, ".ready_after_start"}, 64'(rdy_m), 64'd1);
        wr_q.delete();
        exp_err = 1'b0; nexp = 0; maxw = 0;
        foreach (prog_q[i]) begin
            if (prog_q[i].exp_write) begin
                exp_q.push_back('{32'(nexp), prog_q[i].exp_word, 0});
                nexp++;
            end else begin
                exp_err = 1'b1;
            end
            if (gaps && $urandom_range(3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            send(prog_q[i], 4, acc, w);
            if (!acc) check({tag, ".accept_timeout"}, 64'd0, 64'd1);
            if (w > maxw) maxw = w;
        end
        in_valid = 1'b0; in_last = 1'b0;
        k = 0;
        while (run_m !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check({tag, ".cpu_run"}, 64'(run_m), 64'd1);
        check({tag, ".nwrites"}, 64'(wr_q.size()), 64'(nexp));
        foreach (exp_q[i]) begin
            if (i < wr_q.size()) begin
                check($sformatf("%s.addr%0d", tag, i), 64'(wr_q[i].addr), 64'(exp_q[i].addr));
                check($sformatf("%s.word%0d", tag, i), 64'(wr_q[i].data), 64'(exp_q[i].data));
            end
        end
        if (wr_q.size() > 0 && prog_q[prog_q.size()-1].exp_write)
            check({tag, ".run_lag"}, 64'(cyc - wr_q[wr_q.size()-1].c), 64'd1);
        check({tag, ".word_count"}, 64'(count_m), 64'(nexp));
        check({tag, ".err_kind"}, 64'(err_m), 64'(exp_err));
        check({tag, ".full"}, 64'(full_m), 64'd0);
        if (b2b) begin
            check({tag, ".ready_stall"}, 64'(maxw), 64'd0);
            for (int i = 1; i < wr_q.size(); i++)
                check($sformatf("%s.consec%0d", tag, i), 64'(wr_q[i].c - wr_q[i-1].c), 64'd1);
        end
    endtask

    function automatic vec_t mk(input int g, input int kind, input int rs, input int rt,
                                input int rd, input int funct, input int imm, input int tgt,
                                input bit last, input bit ew, input logic [31:0] word);
        vec_t v;
        v.grp = g; v.kind = 3'(kind); v.rs = 5'(rs); v.rt = 5'(rt); v.rd = 5'(rd);
        v.funct = 6'(funct); v.imm = 16'(imm); v.target = 26'(tgt); v.last = last;
        v.exp_write = ew; v.exp_word = word;
        return v;
    endfunction

    initial begin
        bit acc;
        int w;
        vec_t v;
        sel_small = 1'b0;
        in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_funct = '0;
        in_imm = '0; in_target = '0;
        do_reset();

        check("rst.in_ready", 64'(rdy_m), 64'd0);
        check("rst.imem_we", 64'(we_m), 64'd0);
        check("rst.imem_addr", 64'(addr_m), 64'd0);
        check("rst.imem_wdata", 64'(wdata_m), 64'd0);
        check("rst.word_count", 64'(count_m), 64'd0);
        check("rst.full", 64'(full_m), 64'd0);
        check("rst.err_kind", 64'(err_m), 64'd0);
        check("rst.cpu_run", 64'(run_m), 64'd0);

        // grp 1: LW + R; grp 2: SW, BEQ, J back-to-back; grp 3: unsupported kind between LWs
        table_v.push_back(mk(1, 1, 2, 5, 0, 0,    'h0010, 0, 0, 1, 32'h8C450010));
        table_v.push_back(mk(1, 0, 1, 2, 3, 'h20, 0,      0, 1, 1, 32'h00221820));
        table_v.push_back(mk(2, 2, 4, 6, 0, 0,    'hFFFC, 0, 0, 1, 32'hAC86FFFC));
        table_v.push_back(mk(2, 3, 1, 1, 0, 0,    'hFFFF, 0, 0, 1, 32'h1021FFFF));
        table_v.push_back(mk(2, 4, 0, 0, 0, 0,    0,   'h40, 1, 1, 32'h08000040));
        table_v.push_back(mk(3, 1, 3, 4, 0, 0,    'h1234, 0, 0, 1, 32'h8C641234));
        table_v.push_back(mk(3, 6, 9, 9, 9, 9,    'h5555, 7, 0, 0, 32'h00000000));
        table_v.push_back(mk(3, 1, 0, 7, 0, 0,    'hABCD, 0, 1, 1, 32'h8C07ABCD));

        for (int g = 1; g <= 3; g++) begin
            prog_q.delete();
            foreach (table_v[i]) if (table_v[i].grp == g) prog_q.push_back(table_v[i]);
            run_program($sformatf("vec%0d", g), 1'b0, g == 2);
        end
        repeat (3) @(negedge clk);
        check("vec3.err_sticky", 64'(err_m), 64'd1);

        // Randomized programs against the reference encoder
        for (int p = 0; p < 25; p++) begin
            int len;
            prog_q.delete();
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                v.grp = 0;
                v.kind = ($urandom_range(4) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
                v.rs = 5'($urandom); v.rt = 5'($urandom); v.rd = 5'($urandom);
                v.funct = 6'($urandom); v.imm = 16'($urandom); v.target = 26'($urandom);
                v.last = (i == len - 1);
                v.exp_write = (v.kind <= 3'd4);
                v.exp_word = model_word(v);
                prog_q.push_back(v);
            end
            run_program($sformatf("rnd%0d", p), 1'b1, 1'b0);
        end

        // Restart from DONE with a single J
        prog_q.delete();
        v = mk(0, 4, 0, 0, 0, 0, 0, 'h3FFFFFF, 1, 1, 32'h0);
        v.exp_word = model_word(v);
        prog_q.push_back(v);
        run_program("restart", 1'b0, 1'b0);

        // Capacity limit on the DEPTH=4 instance
        sel_small = 1'b1;
        do_reset();
        start = 1'b1; @(negedge clk); start = 1'b0;
        wr_q.delete();
        for (int i = 0; i < 4; i++) begin
            send(mk(0, 1, i, i + 1, 0, 0, i * 3, 0, 0, 1, 32'h0), 4, acc, w);
            check($sformatf("full.acc%0d", i), 64'(acc), 64'd1);
        end
        send(mk(0, 1, 9, 9, 0, 0, 9, 0, 0, 1, 32'h0), 6, acc, w);
        check("full.fifth_accepted", 64'(acc), 64'd0);
        in_valid = 1'b0;
        start = 1'b1; @(negedge clk); start = 1'b0;   // ignored while in LOAD
        repeat (2) @(negedge clk);
        check("full.nwrites", 64'(wr_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < wr_q.size(); i++)
            check($sformatf("full.addr%0d", i), 64'(wr_q[i].addr), 64'(i));
        check("full.full", 64'(full_m), 64'd1);
        check("full.in_ready", 64'(rdy_m), 64'd0);
        check("full.cpu_run", 64'(run_m), 64'd0);
        check("full.word_count", 64'(count_m), 64'd4);
        sel_small = 1'b0;

        // Reset one cycle after an accept
        do_reset();
        start = 1'b1; @(negedge clk); start = 1'b0;
        send(mk(0, 1, 1, 2, 0, 0, 'h77, 0, 0, 1, 32'h0), 4, acc, w);
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        wr_q.delete();
        check("rst2.imem_we", 64'(we_m), 64'd0);
        check("rst2.imem_addr", 64'(addr_m), 64'd0);
        check("rst2.imem_wdata", 64'(wdata_m), 64'd0);
        check("rst2.word_count", 64'(count_m), 64'd0);
        check("rst2.in_ready", 64'(rdy_m), 64'd0);
        check("rst2.cpu_run", 64'(run_m), 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst2.no_writes", 64'(wr_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
